// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run-completion and watchdog monitor for N_CORES matrix-multiply cores
// Optional SKEW_CYCLES output (last minus first finish cycle) enabled by RUN_MONITOR_SKEW_EN.
module run_monitor #(
  parameter int N_CORES        = 4,
  parameter int CNT_WIDTH      = 22,
  parameter int TIMEOUT_CYCLES = 3000000
) (
  input  logic                          MAIN_CLOCK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [N_CORES-1:0]            CORE_EN,
  input  logic [N_CORES-1:0]            PROCESS_DONE,
  output logic                          BUSY,
  output logic                          ALL_DONE,
  output logic                          TIMEOUT,
  output logic [N_CORES-1:0]            DONE_MASK,
  output logic [N_CORES*CNT_WIDTH-1:0]  CORE_CYCLES,
`ifdef RUN_MONITOR_SKEW_EN
  output logic [CNT_WIDTH-1:0]          SKEW_CYCLES,
`endif
  output logic [CNT_WIDTH-1:0]          TOTAL_CYCLES
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMED_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_K = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [N_CORES-1:0]   ALL_ONES  = '1;

  state_t               state;
  state_t               state_n;
  logic [N_CORES-1:0]   enable_q;
  logic [N_CORES-1:0]   capture;
  logic [N_CORES-1:0]   mask_run;
  logic [CNT_WIDTH-1:0] k;

  // k is the index of the RUN cycle being evaluated on this edge
  assign k        = TOTAL_CYCLES + CNT_WIDTH'(1);
  assign capture  = enable_q & ~DONE_MASK & PROCESS_DONE;
  assign mask_run = DONE_MASK | capture;

  assign BUSY     = (state == S_RUN);
  assign ALL_DONE = (state == S_DONE);
  assign TIMEOUT  = (state == S_TIMED_OUT);

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RUN: begin
        // completion takes priority over the budget expiring on the same cycle
        if (mask_run == ALL_ONES) begin
          state_n = S_DONE;
        end else if (k == TIMEOUT_K) begin
          state_n = S_TIMED_OUT;
        end
      end
      default: begin
        if (START) begin
          state_n = (CORE_EN == '0) ? S_DONE : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      enable_q     <= '0;
      DONE_MASK    <= '0;
      CORE_CYCLES  <= '0;
      TOTAL_CYCLES <= '0;
    end else if (state != S_RUN) begin
      if (START) begin
        enable_q     <= CORE_EN;
        DONE_MASK    <= ~CORE_EN;
        CORE_CYCLES  <= '0;
        TOTAL_CYCLES <= '0;
      end
    end else begin
      DONE_MASK    <= mask_run;
      TOTAL_CYCLES <= k;
      for (int i = 0; i < N_CORES; i++) begin
        if (capture[i]) begin
          CORE_CYCLES[i*CNT_WIDTH +: CNT_WIDTH] <= k;
        end
      end
    end
  end

`ifdef RUN_MONITOR_SKEW_EN
  logic [CNT_WIDTH-1:0] first_k;
  logic [CNT_WIDTH-1:0] last_k;
  logic [CNT_WIDTH-1:0] first_n;
  logic [CNT_WIDTH-1:0] last_n;
  logic                 none_yet;

  assign none_yet = ((DONE_MASK & enable_q) == '0);
  assign first_n  = (none_yet && (capture != '0)) ? k : first_k;
  assign last_n   = (capture != '0) ? k : last_k;

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      first_k     <= '0;
      last_k      <= '0;
      SKEW_CYCLES <= '0;
    end else if (state != S_RUN) begin
      if (START) begin
        first_k     <= '0;
        last_k      <= '0;
        SKEW_CYCLES <= '0;
      end
    end else begin
      first_k <= first_n;
      last_k  <= last_n;
      if (state_n == S_DONE) begin
        SKEW_CYCLES <= last_n - first_n;
      end
    end
  end
`endif

endmodule
